sd_phy_crc_engine: RTL and testbench

//  Parametrised multi-lane serial CRC engine for the SD PHY: one LFSR per lane, one data bit per lane per cycle.

---
 rtl/sd_phy_crc_pkg.sv | 6 +
 rtl/sd_phy_crc_lane.sv | 29 ++
 rtl/sd_phy_crc_engine.sv | 132 +++++++++++++
 tb/tb_sd_phy_crc_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_phy_crc_pkg.sv
// sd_phy_crc_pkg: shared polynomials and FSM encoding for the SD PHY CRC engine
package sd_phy_crc_pkg;
    localparam logic [6:0]  POLY_CRC7  = 7'h09;
    localparam logic [15:0] POLY_CRC16 = 16'h1021;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SHIFT, ST_CHECK} state_e;
endpackage

// File: rtl/sd_phy_crc_lane.sv
// sd_phy_crc_lane: one serial CRC LFSR with clear, update and shift-out controls
module sd_phy_crc_lane
    import sd_phy_crc_pkg::*;
#(
    parameter int             CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY = POLY_CRC7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             upd,
    input  logic             shift,
    input  logic             d,
    output logic [CRC_W-1:0] r,
    output logic             msb_next
);
    logic [CRC_W-1:0] r_q, r_d, base;
    always_comb begin
        base = clr ? '0 : r_q;
        r_d = upd ? ({base[CRC_W-2:0], 1'b0} ^ ((d ^ base[CRC_W-1]) ? POLY : '0))
            : shift ? {base[CRC_W-2:0], 1'b0} : base;
        msb_next = r_d[CRC_W-1];
    end
    always_ff @(posedge clk) begin
        if (reset) r_q <= '0;
        else r_q <= r_d;
    end
    assign r = r_q;
endmodule

// File: rtl/sd_phy_crc_engine.sv
// sd_phy_crc_engine: multi-lane serial CRC generate/shift-out; receive check built only with SD_PHY_CRC_CHECK_EN
module sd_phy_crc_engine
    import sd_phy_crc_pkg::*;
#(
    parameter int               CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY  = POLY_CRC7,
    parameter int               LANES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   data_valid,
    input  logic [LANES-1:0]       data_in,
    input  logic                   emit,
    input  logic                   check,
    output logic [LANES*CRC_W-1:0] crc,
    output logic                   busy,
    output logic [LANES-1:0]       crc_bit,
    output logic                   crc_bit_valid,
    output logic                   crc_done,
    output logic                   chk_done,
    output logic [LANES-1:0]       chk_err
);
    localparam int CNT_W = $clog2(CRC_W + 1);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] crc_bit_q, crc_bit_d, msb_next;
    logic             crc_bit_valid_q, crc_bit_valid_d, crc_done_q, crc_done_d;
    logic             in_accum, in_shift, go_emit, upd, shift;
`ifdef SD_PHY_CRC_CHECK_EN
    logic             in_check, go_check, chk_done_q, chk_done_d;
    logic [LANES-1:0] chk_err_q, chk_err_d, nz;
`else
    logic unused_check;
    assign unused_check = check;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sd_phy_crc_lane #(.CRC_W(CRC_W), .POLY(POLY)) u_lane (
            .clk(clk), .reset(reset), .clr(start), .upd(upd), .shift(shift), .d(data_in[k]),
            .r(crc[k*CRC_W +: CRC_W]), .msb_next(msb_next[k])
        );
`ifdef SD_PHY_CRC_CHECK_EN
        assign nz[k] = |crc[k*CRC_W +: CRC_W];
`endif
    end

    always_comb begin
        in_accum = state_q == ST_ACCUM;
        in_shift = state_q == ST_SHIFT;
        go_emit = in_accum & emit & ~start;
        shift = in_shift & ~start;
        state_d = state_q;
        cnt_d = cnt_q;
        crc_bit_d = '0;
        crc_bit_valid_d = 1'b0;
        crc_done_d = 1'b0;
`ifdef SD_PHY_CRC_CHECK_EN
        in_check = state_q == ST_CHECK;
        go_check = in_accum & check & ~emit & ~start;
        upd = data_valid & (start | in_accum | (in_check & cnt_q != '0));
        chk_done_d = 1'b0;
        chk_err_d = start ? '0 : chk_err_q;
`else
        upd = data_valid & (start | in_accum);
`endif
        if (start) begin
            state_d = ST_ACCUM;
            cnt_d = '0;
        end else if (go_emit) begin
            state_d = ST_SHIFT;
            cnt_d = CNT_W'(CRC_W - 1);
            crc_bit_d = msb_next;
            crc_bit_valid_d = 1'b1;
        end else if (in_shift) begin
            state_d = cnt_q == '0 ? ST_IDLE : ST_SHIFT;
            cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
            crc_bit_d = cnt_q == '0 ? '0 : msb_next;
            crc_bit_valid_d = cnt_q != '0;
            crc_done_d = cnt_q == CNT_W'(1);
`ifdef SD_PHY_CRC_CHECK_EN
        end else if (go_check) begin
            state_d = ST_CHECK;
            cnt_d = CNT_W'(CRC_W);
        end else if (in_check) begin
            // the residue is judged one cycle after the last received CRC bit lands
            state_d = cnt_q == '0 ? ST_IDLE : ST_CHECK;
            cnt_d = (cnt_q != '0 && data_valid) ? cnt_q - 1'b1 : cnt_q;
            chk_done_d = cnt_q == '0;
            chk_err_d = cnt_q == '0 ? nz : chk_err_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            crc_bit_q <= '0;
            crc_bit_valid_q <= 1'b0;
            crc_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            crc_bit_q <= crc_bit_d;
            crc_bit_valid_q <= crc_bit_valid_d;
            crc_done_q <= crc_done_d;
        end
    end

`ifdef SD_PHY_CRC_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_done_q <= 1'b0;
            chk_err_q <= '0;
        end else begin
            chk_done_q <= chk_done_d;
            chk_err_q <= chk_err_d;
        end
    end
    assign chk_done = chk_done_q;
    assign chk_err = chk_err_q;
`else
    assign chk_done = 1'b0;
    assign chk_err = '0;
`endif

    assign busy = state_q != ST_IDLE;
    assign crc_bit = crc_bit_q;
    assign crc_bit_valid = crc_bit_valid_q;
    assign crc_done = crc_done_q;
endmodule

// File: tb/tb_sd_phy_crc_engine.sv
// tb_sd_phy_crc_engine: directed checks of CRC7/CRC16 generate, shift-out, abort, reset and (SD_PHY_CRC_CHECK_EN) check mode
module tb_sd_phy_crc_engine;
    import sd_phy_crc_pkg::*;
    logic clk = 1'b0, reset = 1'b1;
    int n_pass = 0, n_tot = 0;

    logic a_start = 0, a_dv = 0, a_din = 0, a_emit = 0, a_check = 0;
    logic [6:0] a_crc;
    logic a_busy, a_bit, a_bv, a_done, a_cd, a_ce;
    logic b_start = 0, b_dv = 0, b_din = 0, b_emit = 0, b_check = 0;
    logic [15:0] b_crc;
    logic b_busy, b_bit, b_bv, b_done, b_cd, b_ce;
    logic c_start = 0, c_dv = 0, c_emit = 0, c_check = 0;
    logic [3:0] c_din = '0, c_bit, c_ce;
    logic [63:0] c_crc;
    logic c_busy, c_bv, c_done, c_cd;

    always #5 clk = ~clk;

    sd_phy_crc_engine #(.CRC_W(7), .POLY(POLY_CRC7), .LANES(1)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .data_valid(a_dv), .data_in(a_din), .emit(a_emit),
        .check(a_check), .crc(a_crc), .busy(a_busy), .crc_bit(a_bit), .crc_bit_valid(a_bv),
        .crc_done(a_done), .chk_done(a_cd), .chk_err(a_ce));
    sd_phy_crc_engine #(.CRC_W(16), .POLY(POLY_CRC16), .LANES(1)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .data_valid(b_dv), .data_in(b_din), .emit(b_emit),
        .check(b_check), .crc(b_crc), .busy(b_busy), .crc_bit(b_bit), .crc_bit_valid(b_bv),
        .crc_done(b_done), .chk_done(b_cd), .chk_err(b_ce));
    sd_phy_crc_engine #(.CRC_W(16), .POLY(POLY_CRC16), .LANES(4)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .data_valid(c_dv), .data_in(c_din), .emit(c_emit),
        .check(c_check), .crc(c_crc), .busy(c_busy), .crc_bit(c_bit), .crc_bit_valid(c_bv),
        .crc_done(c_done), .chk_done(c_cd), .chk_err(c_ce));

    task automatic a_feed(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            a_dv = 1'b1; a_din = v[i];
            @(negedge clk);
        end
        a_dv = 1'b0;
    endtask

    task automatic b_feed(input logic [15:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            b_dv = 1'b1; b_din = v[i];
            @(negedge clk);
        end
        b_dv = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tot++; if (a_crc !== 7'h00) $display("FAIL reset_a_crc got %h exp 00", a_crc); else n_pass++;
        n_tot++; if (a_busy !== 1'b0) $display("FAIL reset_a_busy got %b exp 0", a_busy); else n_pass++;
        n_tot++; if (a_bv !== 1'b0 || a_bit !== 1'b0) $display("FAIL reset_a_bit got %b%b exp 00", a_bv, a_bit); else n_pass++;
        n_tot++; if (a_done !== 1'b0) $display("FAIL reset_a_done got %b exp 0", a_done); else n_pass++;
        n_tot++; if (a_cd !== 1'b0 || a_ce !== 1'b0) $display("FAIL reset_a_chk got %b%b exp 00", a_cd, a_ce); else n_pass++;
        n_tot++; if (b_crc !== 16'h0 || b_busy !== 1'b0) $display("FAIL reset_b got %h/%b exp 0000/0", b_crc, b_busy); else n_pass++;
        n_tot++; if (c_crc !== 64'h0 || c_busy !== 1'b0 || c_ce !== 4'h0) $display("FAIL reset_c got %h/%b/%h exp 0", c_crc, c_busy, c_ce); else n_pass++;
    endtask

    task automatic test_cmd0_emit;
        logic [6:0] e;
        e = 7'h4A;
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        n_tot++; if (a_busy !== 1'b1 || a_crc !== 7'h00) $display("FAIL cmd0_start got %b/%h exp 1/00", a_busy, a_crc); else n_pass++;
        a_feed(64'h40_00_00_00_00, 40);
        n_tot++; if (a_crc !== 7'h4A) $display("FAIL cmd0_crc got %h exp 4a", a_crc); else n_pass++;
        a_emit = 1'b1; @(negedge clk); a_emit = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_tot++;
            if (a_bv !== 1'b1 || a_bit !== e[6-i] || a_done !== (i == 6))
                $display("FAIL cmd0_bit%0d got v%b b%b d%b exp v1 b%b d%b", i, a_bv, a_bit, a_done, e[6-i], i == 6);
            else n_pass++;
            @(negedge clk);
        end
        n_tot++; if (a_bv !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0 || a_crc !== 7'h00)
            $display("FAIL cmd0_end got v%b d%b busy%b crc%h exp 0/0/0/00", a_bv, a_done, a_busy, a_crc); else n_pass++;
        a_emit = 1'b1; a_dv = 1'b1; a_din = 1'b1; @(negedge clk); a_emit = 1'b0; a_dv = 1'b0;
        n_tot++; if (a_bv !== 1'b0 || a_busy !== 1'b0 || a_crc !== 7'h00)
            $display("FAIL idle_ignore got v%b busy%b crc%h exp 0/0/00", a_bv, a_busy, a_crc); else n_pass++;
    endtask

    task automatic test_cmd8_check;
        bit got;
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        a_feed(64'h48_00_00_01_AA, 40);
        n_tot++; if (a_crc !== 7'h43) $display("FAIL cmd8_crc got %h exp 43", a_crc); else n_pass++;
        a_check = 1'b1; @(negedge clk); a_check = 1'b0;
        n_tot++; if (a_busy !== 1'b1 || a_crc !== 7'h43) $display("FAIL cmd8_chk_entry got %b/%h exp 1/43", a_busy, a_crc); else n_pass++;
        a_feed(64'h43, 7);
        n_tot++; if (a_crc !== 7'h00) $display("FAIL cmd8_residue got %h exp 00", a_crc); else n_pass++;
`ifdef SD_PHY_CRC_CHECK_EN
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (a_cd === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        n_tot++; if (got !== 1'b1 || a_ce !== 1'b0) $display("FAIL cmd8_chk_done got done%b err%b exp 1/0", got, a_ce); else n_pass++;
        @(negedge clk);
        n_tot++; if (a_cd !== 1'b0 || a_busy !== 1'b0) $display("FAIL cmd8_chk_pulse got %b/%b exp 0/0", a_cd, a_busy); else n_pass++;
`else
        got = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_cd !== 1'b0 || a_ce !== 1'b0) got = 1'b1;
        end
        n_tot++; if (got !== 1'b0 || a_busy !== 1'b1) $display("FAIL cmd8_chk_ignored got chk%b busy%b exp 0/1", got, a_busy); else n_pass++;
`endif
    endtask

    task automatic test_crc16_ones;
        bit got;
        b_start = 1'b1; @(negedge clk); b_start = 1'b0;
        b_dv = 1'b1; b_din = 1'b1;
        repeat (4096) @(negedge clk);
        b_dv = 1'b0;
        n_tot++; if (b_crc !== 16'h7FA1) $display("FAIL crc16_ones got %h exp 7fa1", b_crc); else n_pass++;
        b_check = 1'b1; @(negedge clk); b_check = 1'b0;
        b_feed(16'h7FA0, 15, 8);
        @(negedge clk);
        b_feed(16'h7FA0, 7, 0);
        n_tot++; if (b_crc !== 16'h1021) $display("FAIL crc16_residue got %h exp 1021", b_crc); else n_pass++;
`ifdef SD_PHY_CRC_CHECK_EN
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (b_cd === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        n_tot++; if (got !== 1'b1 || b_ce !== 1'b1) $display("FAIL crc16_chk got done%b err%b exp 1/1", got, b_ce); else n_pass++;
        @(negedge clk);
        n_tot++; if (b_cd !== 1'b0 || b_ce !== 1'b1) $display("FAIL crc16_chk_hold got %b/%b exp 0/1", b_cd, b_ce); else n_pass++;
`endif
        b_start = 1'b1; @(negedge clk); b_start = 1'b0;
        n_tot++; if (b_ce !== 1'b0 || b_cd !== 1'b0 || b_crc !== 16'h0) $display("FAIL crc16_restart got %b/%b/%h exp 0/0/0000", b_ce, b_cd, b_crc); else n_pass++;
    endtask

    task automatic test_multilane;
        logic [15:0] e;
        e = 16'h7FA1;
        c_start = 1'b1; @(negedge clk); c_start = 1'b0;
        c_dv = 1'b1; c_din = 4'b1000;
        repeat (4096) @(negedge clk);
        c_dv = 1'b0; c_din = 4'b0000;
        n_tot++; if (c_crc !== {16'h7FA1, 48'h0}) $display("FAIL lanes_crc got %h exp 7fa1000000000000", c_crc); else n_pass++;
        c_emit = 1'b1; @(negedge clk); c_emit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_tot++;
            if (c_bv !== 1'b1 || c_bit !== {e[15-i], 3'b000} || c_done !== (i == 15))
                $display("FAIL lanes_bit%0d got v%b b%b d%b exp v1 b%b000 d%b", i, c_bv, c_bit, c_done, e[15-i], i == 15);
            else n_pass++;
            @(negedge clk);
        end
        n_tot++; if (c_bv !== 1'b0 || c_busy !== 1'b0 || c_crc !== 64'h0) $display("FAIL lanes_end got %b/%b/%h exp 0/0/0", c_bv, c_busy, c_crc); else n_pass++;
    endtask

    task automatic test_abort_shift;
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        a_feed(64'h40_00_00_00_00, 40);
        a_emit = 1'b1; @(negedge clk); a_emit = 1'b0;
        n_tot++; if (a_bv !== 1'b1) $display("FAIL abort_pre got %b exp 1", a_bv); else n_pass++;
        @(negedge clk);
        a_start = 1'b1; a_dv = 1'b1; a_din = 1'b1; @(negedge clk);
        a_start = 1'b0; a_dv = 1'b0; a_din = 1'b0;
        n_tot++; if (a_bv !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b1 || a_crc !== 7'h09)
            $display("FAIL abort_shift got v%b d%b busy%b crc%h exp 0/0/1/09", a_bv, a_done, a_busy, a_crc); else n_pass++;
        a_feed(64'h0, 1);
        n_tot++; if (a_crc !== 7'h12) $display("FAIL abort_accum got %h exp 12", a_crc); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit seen;
        b_start = 1'b1; @(negedge clk); b_start = 1'b0;
        b_feed(16'hFFFF, 15, 0);
        b_check = 1'b1; @(negedge clk); b_check = 1'b0;
        b_feed(16'hFFFF, 4, 0);
        reset = 1'b1; b_dv = 1'b1; b_din = 1'b1; @(negedge clk);
        reset = 1'b0; b_dv = 1'b0;
        n_tot++; if (b_crc !== 16'h0 || b_busy !== 1'b0 || b_bv !== 1'b0 || b_cd !== 1'b0 || b_ce !== 1'b0)
            $display("FAIL reset_mid got crc%h busy%b v%b cd%b ce%b exp all 0", b_crc, b_busy, b_bv, b_cd, b_ce); else n_pass++;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (b_cd !== 1'b0 || b_busy !== 1'b0) seen = 1'b1;
        end
        n_tot++; if (seen !== 1'b0) $display("FAIL reset_mid_quiet got %b exp 0", seen); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_cmd0_emit;
        test_cmd8_check;
        test_crc16_ones;
        test_multilane;
        test_abort_shift;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
